// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller: FSM states,
// register window indices and the width of a source id.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } irq_state_t;

  localparam logic [1:0] IRQ_PEND   = 2'd0;
  localparam logic [1:0] IRQ_MASK   = 2'd1;
  localparam logic [1:0] IRQ_VECTOR = 2'd2;
  localparam logic [1:0] IRQ_ACK    = 2'd3;

  localparam int IRQ_ID_W = 4;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set request index and whether
// any request is set. Index 0 has the highest priority.
module irq_prio_enc #(
  parameter int N  = 4,
  parameter int IW = 4
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the top down so the lowest set index is the one left standing
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = req[i] ? IW'(i) : idx;
      any = any | req[i];
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: per-source edge detect, pending and mask registers,
// fixed-priority selection and a non-preemptive nIRQ handshake with the CPU.
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [NUM_SRC-1:0] Irq,
  input  logic               Sel,
  input  logic               RnW,
  input  logic [1:0]         Addr,
  input  logic [15:0]        WData,
  output logic [15:0]        RData,
  output logic               nIRQ
);

  logic [NUM_SRC-1:0]  irq_q_r;
  logic [NUM_SRC-1:0]  pend_r;
  logic [NUM_SRC-1:0]  mask_r;
  logic [NUM_SRC-1:0]  rise_s;
  logic [NUM_SRC-1:0]  ack_clr_s;
  logic [NUM_SRC-1:0]  elig_s;
  logic [IRQ_ID_W-1:0] insvc_r;
  logic [IRQ_ID_W-1:0] ack_id_s;
  logic [IRQ_ID_W-1:0] enc_idx_s;
  logic                enc_any_s;
  logic                wr_s;
  logic                ack_wr_s;
  logic                ack_svc_s;
  logic                nirq_r;
  logic [15:0]         rdata_s;
  irq_state_t          state_r;

  assign wr_s      = Sel & ~RnW;
  assign ack_wr_s  = wr_s & (Addr == IRQ_ACK);
  assign ack_id_s  = WData[IRQ_ID_W-1:0];
  assign rise_s    = Irq & ~irq_q_r;
  assign elig_s    = pend_r & mask_r;
  assign ack_svc_s = ack_wr_s & (ack_id_s == insvc_r);

  // Decode the ACK id into a one-hot clear; ids beyond NUM_SRC match nothing
  always_comb begin
    ack_clr_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ack_clr_s[i] = ack_wr_s & (ack_id_s == IRQ_ID_W'(i));
    end
  end

  irq_prio_enc #(
    .N  (NUM_SRC),
    .IW (IRQ_ID_W)
  ) u_prio_enc (
    .req (elig_s),
    .idx (enc_idx_s),
    .any (enc_any_s)
  );

  // Edge history, pending and mask registers; a new edge beats a same-cycle ACK
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      irq_q_r <= '0;
      pend_r  <= '0;
      mask_r  <= '0;
    end else begin
      irq_q_r <= Irq;
      pend_r  <= (pend_r & ~ack_clr_s) | rise_s;
      if (wr_s && (Addr == IRQ_MASK)) begin
        mask_r <= NUM_SRC'(WData);
      end
    end
  end

  // Handshake FSM; GAP forces one visible high cycle between interrupts
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
      insvc_r <= '0;
      nirq_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (enc_any_s) begin
            insvc_r <= enc_idx_s;
            state_r <= ACTIVE;
            nirq_r  <= 1'b0;
          end
        end
        ACTIVE: begin
          if (ack_svc_s) begin
            state_r <= GAP;
            nirq_r  <= 1'b1;
          end
        end
        GAP: begin
          state_r <= IDLE;
          nirq_r  <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          nirq_r  <= 1'b1;
        end
      endcase
    end
  end

  // Read mux; the bus sees zero unless a read of this window is in progress
  always_comb begin
    rdata_s = 16'h0000;
    if (Sel & RnW) begin
      case (Addr)
        IRQ_PEND:   rdata_s = 16'(pend_r);
        IRQ_MASK:   rdata_s = 16'(mask_r);
        IRQ_VECTOR: rdata_s = {(state_r == ACTIVE), 11'h000, insvc_r};
        default:    rdata_s = 16'h0000;
      endcase
    end else begin
      rdata_s = 16'h0000;
    end
  end

  assign RData = rdata_s;
  assign nIRQ  = nirq_r;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus random bus
// and request traffic compared against a behavioural model.
module tb_irq_controller;

  localparam int N = 4;

  logic         Clock;
  logic         Reset;
  logic [N-1:0] Irq;
  logic         Sel;
  logic         RnW;
  logic [1:0]   Addr;
  logic [15:0]  WData;
  logic [15:0]  RData;
  logic         nIRQ;

  int total  = 0;
  int passed = 0;

  // Behavioural model: bitmask integers and a phase number (0 idle, 1 active, 2 gap)
  int   m_pend, m_mask, m_last, m_svc, m_phase;
  logic m_nirq;
  logic [3:0] cur_irq;

  irq_controller #(.NUM_SRC(N)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Irq   (Irq),
    .Sel   (Sel),
    .RnW   (RnW),
    .Addr  (Addr),
    .WData (WData),
    .RData (RData),
    .nIRQ  (nIRQ)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic model_reset();
    m_pend  = 0;
    m_mask  = 0;
    m_last  = 0;
    m_svc   = 0;
    m_phase = 0;
    m_nirq  = 1'b1;
  endtask

  function automatic logic [15:0] model_rdata(input logic sel, input logic rnw, input logic [1:0] addr);
    if (!(sel && rnw)) return 16'h0000;
    case (addr)
      2'd0:    return 16'(m_pend);
      2'd1:    return 16'(m_mask);
      2'd2:    return 16'(((m_phase == 1) ? 32'h8000 : 32'h0) | m_svc);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic void model_step(input logic [3:0] irq, input logic sel, input logic rnw,
                                     input logic [1:0] addr, input logic [15:0] wd);
    int all, ackid, rises, npend, elig, lowest;
    all   = (1 << N) - 1;
    ackid = -1;
    if (sel && !rnw && addr == 2'd3) ackid = int'(wd[3:0]);
    rises = int'(irq) & ~m_last & all;
    npend = m_pend;
    if (ackid >= 0 && ackid < N) npend = npend & ~(1 << ackid);
    npend = npend | rises;
    elig  = m_pend & m_mask;
    if (m_phase == 0) begin
      if (elig != 0) begin
        lowest = 0;
        while (((elig >> lowest) & 1) == 0) lowest++;
        m_svc   = lowest;
        m_phase = 1;
        m_nirq  = 1'b0;
      end
    end else if (m_phase == 1) begin
      if (ackid == m_svc) begin
        m_phase = 2;
        m_nirq  = 1'b1;
      end
    end else begin
      m_phase = 0;
    end
    if (sel && !rnw && addr == 2'd1) m_mask = int'(wd) & all;
    m_pend = npend;
    m_last = int'(irq);
  endfunction

  // One clock cycle from a falling edge: drive, check read data, clock, check nIRQ
  task automatic cyc(input logic [3:0] irq, input logic sel, input logic rnw,
                     input logic [1:0] addr, input logic [15:0] wd);
    cur_irq = irq;
    Irq = irq; Sel = sel; RnW = rnw; Addr = addr; WData = wd;
    #1;
    check("rdata", RData, model_rdata(sel, rnw, addr));
    @(posedge Clock);
    model_step(irq, sel, rnw, addr, wd);
    #1;
    check("nirq", {15'd0, nIRQ}, {15'd0, m_nirq});
    @(negedge Clock);
  endtask

  task automatic rd(input string tag, input logic [1:0] addr, input logic [15:0] exp);
    Irq = cur_irq; Sel = 1'b1; RnW = 1'b1; Addr = addr; WData = 16'h0000;
    #1;
    check(tag, RData, exp);
    cyc(cur_irq, 1'b1, 1'b1, addr, 16'h0000);
  endtask

  task automatic wr(input logic [1:0] addr, input logic [15:0] wd);
    cyc(cur_irq, 1'b0 | 1'b1, 1'b0, addr, wd);
  endtask

  task automatic idle(input logic [3:0] irq);
    cyc(irq, 1'b0, 1'b1, 2'd0, 16'h0000);
  endtask

  task automatic chk_nirq(input string tag, input logic exp);
    check(tag, {15'd0, nIRQ}, {15'd0, exp});
  endtask

  initial begin
    cur_irq = 4'h0;
    Reset = 1'b1; Irq = 4'h0; Sel = 1'b0; RnW = 1'b1; Addr = 2'd0; WData = 16'h0000;
    model_reset();
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;

    // 1: reset state
    #1;
    check("rst_rdata_unsel", RData, 16'h0000);
    chk_nirq("rst_nirq", 1'b1);
    rd("rst_pend", 2'd0, 16'h0000);
    rd("rst_mask", 2'd1, 16'h0000);
    rd("rst_vector", 2'd2, 16'h0000);
    rd("rst_ack_read", 2'd3, 16'h0000);

    // 2: single source, ACK and one-cycle gap
    wr(2'd1, 16'h000F);
    idle(4'h4);
    chk_nirq("p2_nirq_after1", 1'b1);
    cur_irq = 4'h0;
    rd("p2_pend", 2'd0, 16'h0004);
    chk_nirq("p2_nirq_after2", 1'b0);
    rd("p2_vector", 2'd2, 16'h8002);
    wr(2'd3, 16'h0002);
    chk_nirq("p2_gap_high", 1'b1);
    idle(4'h0);
    chk_nirq("p2_idle_high", 1'b1);
    rd("p2_pend_clear", 2'd0, 16'h0000);

    // 3: simultaneous sources resolved by priority
    idle(4'hA);
    idle(4'h0);
    rd("p3_vector1", 2'd2, 16'h8001);
    wr(2'd3, 16'h0001);
    chk_nirq("p3_gap", 1'b1);
    idle(4'h0);
    idle(4'h0);
    chk_nirq("p3_reassert", 1'b0);
    rd("p3_vector3", 2'd2, 16'h8003);
    wr(2'd3, 16'h0003);
    idle(4'h0);
    rd("p3_vector_idle", 2'd2, 16'h0003);

    // 4: masked pending, then unmask
    wr(2'd1, 16'h0000);
    idle(4'h1);
    cur_irq = 4'h0;
    rd("p4_pend", 2'd0, 16'h0001);
    idle(4'h0);
    chk_nirq("p4_masked", 1'b1);
    wr(2'd1, 16'h0001);
    chk_nirq("p4_unmask_m", 1'b1);
    idle(4'h0);
    chk_nirq("p4_unmask_m1", 1'b0);
    wr(2'd3, 16'h0000);
    idle(4'h0);

    // 5: new edge in the ACK cycle of the same source
    wr(2'd1, 16'h000F);
    idle(4'h4);
    idle(4'h0);
    cyc(4'h4, 1'b1, 1'b0, 2'd3, 16'h0002);
    rd("p5_pend_kept", 2'd0, 16'h0004);
    idle(4'h4);
    chk_nirq("p5_reassert", 1'b0);
    rd("p5_vector", 2'd2, 16'h8002);
    wr(2'd3, 16'h0002);
    idle(4'h0);

    // 6: held request counts once; asynchronous reset while active
    for (int i = 0; i < 10; i++) idle(4'h2);
    cyc(4'h2, 1'b1, 1'b0, 2'd3, 16'h0001);
    idle(4'h2);
    rd("p6_single_event", 2'd0, 16'h0000);
    idle(4'h0);
    idle(4'h2);
    idle(4'h0);
    chk_nirq("p6_active", 1'b0);
    Irq = 4'h0; Sel = 1'b1; RnW = 1'b1; Addr = 2'd0;
    #2 Reset = 1'b1;
    #1;
    chk_nirq("p6_rst_nirq", 1'b1);
    check("p6_rst_pend", RData, 16'h0000);
    Addr = 2'd2;
    #1;
    check("p6_rst_vector", RData, 16'h0000);
    model_reset();
    cur_irq = 4'h0;
    @(negedge Clock);
    Reset = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [3:0]  r_irq;
      logic        r_sel;
      logic        r_rnw;
      logic [1:0]  r_addr;
      logic [15:0] r_wd;
      r_irq  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : cur_irq;
      r_sel  = ($urandom_range(0, 2) == 0);
      r_rnw  = 1'($urandom);
      r_addr = 2'($urandom);
      r_wd   = (r_addr == 2'd3) ? 16'($urandom_range(0, 6)) : 16'($urandom);
      cyc(r_irq, r_sel, r_rnw, r_addr, r_wd);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt controller that shares the CPU's single `nIRQ` line between the peripheral slaves on the demux bus (timer, serial, switches, spare). It edge-detects per-source requests, holds them pending, and applies a per-source mask. Among unmasked pending sources, a fixed-priority scheduler picks one to present to the CPU. It decodes as one more bus slave, with a 4-word register window selected by the decoder.

## Interface
Parameters:
- `NUM_SRC`, 4: number of interrupt sources, 1..16; source 0 has the highest priority.

Ports:
- `Clock`  in  1  system clock; all state changes on its rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Irq`  in  NUM_SRC  per-source request lines, synchronous to `Clock`; the rising edge is significant.
- `Sel`  in  1  register window select from the decoder, active-high.
- `RnW`  in  1  1 = read, 0 = write.
- `Addr`  in  2  register index.
- `WData`  in  16  write data.
- `RData`  out  16  read data; combinational.
- `nIRQ`  out  1  interrupt to the CPU, active-low; registered.

## Operation
Registers (`Addr`):
- 0 PEND, read-only: bits [NUM_SRC-1:0] = Pending; other bits read 0.
- 1 MASK, read/write: bit i = 1 enables source i.
- 2 VECTOR, read-only:
  - bit 15 = Active (state ACTIVE).
  - bits [3:0] = InService id.
  - other bits read 0.
- 3 ACK, write-only: writing clears `Pending[WData[3:0]]`. Ids ≥ NUM_SRC are ignored. Reads return 0.

Register access rules:
- `RData` = selected register when `Sel & RnW`; otherwise 0.
- Writes take effect at the rising edge while `Sel & !RnW`.
- Reads have no side effects.

Edge detect:
- `IrqQ` holds last cycle's `Irq`.
- `Pending[i]` is set at an edge where `Irq[i]=1` and `IrqQ[i]=0`.
- A held-high `Irq` sets Pending only once.

State machine, states IDLE, ACTIVE, GAP:
- IDLE: when `Pending & MASK` ≠ 0, latch the lowest set index into InService, go to ACTIVE, and drive `nIRQ`<=0.
- ACTIVE: `nIRQ` stays low.
  - An ACK write with id == InService clears that Pending bit, goes to GAP, and drives `nIRQ`<=1.
  - An ACK write with any other id clears only that bit and stays in ACTIVE.
  - No preemption: a higher-priority arrival or a MASK change does not alter InService.
- GAP: stays exactly one cycle with `nIRQ` high, then returns to IDLE. This guarantees a visible deassertion between interrupts.

Boundary rules:
- New edge and ACK for the same source in the same cycle: set wins, Pending stays 1.
- Pending is still recorded for masked sources; unmasking a pending source later triggers it.
- In ACTIVE, pending bits of masked sources are irrelevant to the state machine.
- Reset mid-operation returns to IDLE immediately (asynchronous). Any interrupt in flight is lost.

## Timing
- Reset values:
  - `nIRQ`=1.
  - Pending, MASK, IrqQ, InService = 0.
  - State IDLE.
  - `RData`=0 while `Sel`=0.
- Latency, `Irq` rise to `nIRQ` low: `Irq[i]` high first sampled at edge k sets Pending after k; `nIRQ` falls after edge k+1 (if unmasked and IDLE).
- ACK of the in-service source at edge a:
  - `nIRQ` high after a.
  - The next interrupt can assert after edge a+2 at the earliest.
- Unmask write at edge m with Pending already set: `nIRQ` low after m+1.

## Structure
- Shared package `opcodes`-style (new `irq_pkg`):
  - state enum `irq_state_t` {IDLE, ACTIVE, GAP}.
  - register index constants `IRQ_PEND`=0, `IRQ_MASK`=1, `IRQ_VECTOR`=2, `IRQ_ACK`=3.
  - `IRQ_ID_W`=4.
- One sub-module is natural: `irq_prio_enc`, a parameterised priority encoder producing the lowest set index plus an any-set flag.
- The bus-interface adapter to `demux_bus` stays outside the block, in the system top.

## Test plan
1. Reset, then read all registers → PEND=0, MASK=0, VECTOR=0x0000, `nIRQ`=1.
2. MASK=0x000F; pulse `Irq[2]` → PEND=0x0004 after 1 edge, `nIRQ`=0 after 2 edges, VECTOR=0x8002; ACK 2 → `nIRQ`=1 for exactly one cycle; PEND=0.
3. `Irq[3]` and `Irq[1]` rise in the same cycle with MASK=0xF → VECTOR=0x8001; ACK 1 → GAP, then VECTOR=0x8003 and `nIRQ` low again; ACK 3 → IDLE.
4. MASK=0; pulse `Irq[0]` → PEND=0x0001, `nIRQ` stays 1; write MASK=1 → `nIRQ`=0 after 2 edges.
5. ACTIVE on source 2; raise `Irq[2]` again in the ACK cycle → PEND bit 2 stays 1, and after GAP the controller re-asserts with VECTOR=0x8002.
6. Hold `Irq[1]` high for 10 cycles → single pending event; assert Reset while ACTIVE → `nIRQ`=1 and PEND=0 immediately, without waiting for a clock edge.
